// File: rtl/load_store_ctrl_if.sv
// Bus bundle between the MEM stage, the load/store controller and the data memory.
// The master modport is the controller side; the slave modport is the CPU/memory environment.
interface load_store_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] load_data;
    logic              memory_read;
    logic              memory_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output busy, done, err, load_data, memory_read, memory_write, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  busy, done, err, load_data, memory_read, memory_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_ctrl.sv
// Data-memory initiator: byte/half/word loads with extension, stores with read-modify-write
// for sub-word sizes. Memory writes on negedge and reads combinationally; byte lanes are big-endian.
module load_store_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_ctrl_if.master   bus
);
    localparam int unsigned BA_W = ADDR_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              accept_c;
    logic              bad_c;
    logic              store_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [15:0]       wdata_q;
    logic [DATA_W-1:0] merged_c;
    logic [DATA_W-1:0] extended_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;

    logic              busy_d, done_d, err_d, rd_d, wr_d;
    logic [DATA_W-1:0] mem_wdata_d, load_data_d;

    assign accept_c = (state_q == S_IDLE) && bus.req_valid;

    // Alignment / legality check on the incoming request
    always_comb begin
        bad_c = 1'b0;
        unique case (bus.req_size)
            2'b00:   bad_c = 1'b0;
            2'b01:   bad_c = bus.req_addr[0];
            2'b10:   bad_c = (bus.req_addr[1:0] != 2'b00);
            default: bad_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (bad_c)                       state_d = S_DONE;
                    else if (!bus.req_store)         state_d = S_READ;
                    else if (bus.req_size == 2'b10)  state_d = S_WRITE;
                    else                             state_d = S_READ;
                end
            end
            S_READ:  state_d = store_q ? S_WRITE : S_DONE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sub-word store: replace the addressed lane(s) of the word just read
    always_comb begin
        merged_c = bus.mem_rdata;
        if (size_q == 2'b00) begin
            unique case (off_q)
                2'd0:    merged_c[31:24] = wdata_q[7:0];
                2'd1:    merged_c[23:16] = wdata_q[7:0];
                2'd2:    merged_c[15:8]  = wdata_q[7:0];
                default: merged_c[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged_c[15:0] = wdata_q;
        end else begin
            merged_c[31:16] = wdata_q;
        end
    end

    // Load lane select and sign/zero extension
    always_comb begin
        unique case (off_q)
            2'd0:    byte_c = bus.mem_rdata[31:24];
            2'd1:    byte_c = bus.mem_rdata[23:16];
            2'd2:    byte_c = bus.mem_rdata[15:8];
            default: byte_c = bus.mem_rdata[7:0];
        endcase
        half_c = off_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
        unique case (size_q)
            2'b00:   extended_c = uns_q ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
            2'b01:   extended_c = uns_q ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
            default: extended_c = bus.mem_rdata;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        rd_d        = (state_d == S_READ);
        wr_d        = (state_d == S_WRITE);
        err_d       = accept_c && bad_c;
        mem_wdata_d = '0;
        load_data_d = bus.load_data;
        if (state_d == S_WRITE) begin
            mem_wdata_d = (state_q == S_READ) ? merged_c : bus.req_wdata;
        end
        if ((state_q == S_READ) && !store_q) begin
            load_data_d = extended_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.memory_read  <= 1'b0;
            bus.memory_write <= 1'b0;
            bus.mem_wdata    <= '0;
            bus.load_data    <= '0;
        end else begin
            bus.busy         <= busy_d;
            bus.done         <= done_d;
            bus.err          <= err_d;
            bus.memory_read  <= rd_d;
            bus.memory_write <= wr_d;
            bus.mem_wdata    <= mem_wdata_d;
            bus.load_data    <= load_data_d;
        end
    end

    // Request fields captured at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_addr <= '0;
            store_q      <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            wdata_q      <= '0;
        end else if (accept_c) begin
            bus.mem_addr <= bus.req_addr[BA_W-1:2];
            store_q      <= bus.req_store;
            uns_q        <= bus.req_unsigned;
            size_q       <= bus.req_size;
            off_q        <= bus.req_addr[1:0];
            wdata_q      <= bus.req_wdata[15:0];
        end
    end
endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: directed vector table, reset/held-request sequences,
// then random traffic against a byte-array memory model.
module tb_load_store_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_ctrl_if bus ();
    load_store_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] wmem [256];
    logic [7:0]  rm   [1024];
    logic [31:0] junk;
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_ld;

    // Memory: combinational read only while strobed, write on negedge
    assign bus.mem_rdata = bus.memory_read ? wmem[bus.mem_addr] : junk;
    always @(negedge clk) begin
        junk <= $urandom;
        if (bus.memory_write) wmem[bus.mem_addr] <= bus.mem_wdata;
    end

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        un;
        logic [9:0]  a;
        logic [31:0] wd;
        logic        e_err;
        int          e_lat;
        logic [31:0] e_ld;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed big-endian memory, request semantics straight from the rules
    task automatic model_req(input logic st, input logic [1:0] sz, input logic un,
                             input logic [9:0] a, input logic [31:0] wd,
                             output int lat, output logic e, output logic [31:0] ld);
        int n;
        logic [31:0] v;
        e  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        ld = exp_ld;
        if (e) begin
            lat = 1;
            return;
        end
        n = 1 << sz;
        if (st) begin
            lat = (n == 4) ? 2 : 3;
            for (int k = 0; k < n; k++) rm[int'(a) + k] = 8'(wd >> (8 * (n - 1 - k)));
        end else begin
            lat = 2;
            v = 0;
            for (int k = 0; k < n; k++) v = (v << 8) | 32'(rm[int'(a) + k]);
            if (n == 4 || un)  ld = v;
            else if (n == 1)   ld = {{24{v[7]}}, v[7:0]};
            else               ld = {{16{v[15]}}, v[15:0]};
        end
    endtask

    task automatic run_req(input logic st, input logic [1:0] sz, input logic un,
                           input logic [9:0] a, input logic [31:0] wd,
                           input int e_lat, input logic e_err, input logic [31:0] e_ld,
                           input string tag);
        int cyc, nrd, nwr;
        logic addr_ok, wd_ok, busy_ok, excl_ok;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
        bus.req_unsigned = un; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc = 1; nrd = 0; nwr = 0;
        addr_ok = 1; wd_ok = 1; busy_ok = 1; excl_ok = 1;
        forever begin
            if (bus.memory_read)  nrd++;
            if (bus.memory_write) nwr++;
            if (bus.memory_read && bus.memory_write) excl_ok = 0;
            if ((bus.memory_read || bus.memory_write) && bus.mem_addr != a[9:2]) addr_ok = 0;
            if (!bus.memory_write && bus.mem_wdata != 0) wd_ok = 0;
            if (!bus.busy) busy_ok = 0;
            if (bus.done || cyc >= 8) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(e_lat));
        chk({tag, "_err"}, 32'(bus.err), 32'(e_err));
        chk({tag, "_load_data"}, bus.load_data, e_ld);
        chk({tag, "_reads"}, 32'(nrd), (!e_err && (!st || sz != 2'b10)) ? 32'd1 : 32'd0);
        chk({tag, "_writes"}, 32'(nwr), (!e_err && st) ? 32'd1 : 32'd0);
        chk({tag, "_strobe_excl_addr_wdata_busy"}, {28'd0, excl_ok, addr_ok, wd_ok, busy_ok}, 32'hF);
        @(posedge clk); #1;
        chk({tag, "_idle_after"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    task automatic vec(input logic st, input logic [1:0] sz, input logic un, input logic [9:0] a,
                       input logic [31:0] wd, input logic e, input int lat, input logic [31:0] ld);
        vec_t v;
        v.st = st; v.sz = sz; v.un = un; v.a = a; v.wd = wd;
        v.e_err = e; v.e_lat = lat; v.e_ld = ld;
        tbl.push_back(v);
    endtask

    task automatic no_done_for(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int lat;
        logic e;
        logic [31:0] ld;
        logic [31:0] x;
        logic [1:0] sz;
        logic [31:0] word;
        int bad_words;

        for (int w = 0; w < 256; w++) begin
            x = $urandom;
            wmem[w] = x;
            for (int k = 0; k < 4; k++) rm[4 * w + k] = 8'(x >> (24 - 8 * k));
        end
        junk = 32'h5A5A_A5A5;
        bus.req_valid = 0; bus.req_store = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;
        exp_ld = 0;
        rst_n = 1'b0;
        #1;
        chk("reset_flags", {26'd0, bus.busy, bus.done, bus.err, bus.memory_read, bus.memory_write, 1'b0}, 32'd0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
        chk("reset_load_data", bus.load_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // st sz un addr wdata err lat load_data
        vec(1, 2'd2, 0, 10'h010, 32'hDEADBEEF, 0, 2, 32'h00000000);
        vec(0, 2'd2, 0, 10'h010, 32'h0,        0, 2, 32'hDEADBEEF);
        vec(1, 2'd2, 0, 10'h010, 32'h11223344, 0, 2, 32'hDEADBEEF);
        vec(1, 2'd0, 0, 10'h012, 32'h000000AA, 0, 3, 32'hDEADBEEF);
        vec(0, 2'd2, 0, 10'h010, 32'h0,        0, 2, 32'h1122AA44);
        vec(0, 2'd0, 0, 10'h012, 32'h0,        0, 2, 32'hFFFFFFAA);
        vec(0, 2'd0, 1, 10'h012, 32'h0,        0, 2, 32'h000000AA);
        vec(1, 2'd2, 0, 10'h010, 32'h11223344, 0, 2, 32'h000000AA);
        vec(1, 2'd1, 0, 10'h010, 32'h00008001, 0, 3, 32'h000000AA);
        vec(0, 2'd2, 0, 10'h010, 32'h0,        0, 2, 32'h80013344);
        vec(0, 2'd1, 0, 10'h010, 32'h0,        0, 2, 32'hFFFF8001);
        vec(0, 2'd1, 1, 10'h010, 32'h0,        0, 2, 32'h00008001);
        vec(0, 2'd2, 0, 10'h011, 32'h0,        1, 1, 32'h00008001);
        vec(1, 2'd1, 0, 10'h013, 32'h0000FFFF, 1, 1, 32'h00008001);
        vec(0, 2'd3, 0, 10'h010, 32'h0,        1, 1, 32'h00008001);
        vec(0, 2'd1, 1, 10'h012, 32'h0,        0, 2, 32'h00003344);
        vec(0, 2'd0, 0, 10'h013, 32'h0,        0, 2, 32'h00000044);
        vec(0, 2'd0, 0, 10'h011, 32'h0,        0, 2, 32'h00000001);
        vec(0, 2'd0, 1, 10'h010, 32'h0,        0, 2, 32'h00000080);
        vec(0, 2'd0, 0, 10'h010, 32'h0,        0, 2, 32'hFFFFFF80);
        vec(1, 2'd0, 0, 10'h010, 32'h123456FE, 0, 3, 32'hFFFFFF80);
        vec(1, 2'd0, 0, 10'h013, 32'h00000077, 0, 3, 32'hFFFFFF80);
        vec(1, 2'd1, 0, 10'h012, 32'h0000ABCD, 0, 3, 32'hFFFFFF80);
        vec(0, 2'd2, 0, 10'h010, 32'h0,        0, 2, 32'hFE01ABCD);
        vec(0, 2'd1, 0, 10'h012, 32'h0,        0, 2, 32'hFFFFABCD);
        vec(1, 2'd2, 0, 10'h012, 32'h0,        1, 1, 32'hFFFFABCD);

        foreach (tbl[i]) begin
            model_req(tbl[i].st, tbl[i].sz, tbl[i].un, tbl[i].a, tbl[i].wd, lat, e, ld);
            exp_ld = ld;
            run_req(tbl[i].st, tbl[i].sz, tbl[i].un, tbl[i].a, tbl[i].wd,
                    tbl[i].e_lat, tbl[i].e_err, tbl[i].e_ld, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a READ
        @(negedge clk);
        bus.req_valid = 1; bus.req_store = 0; bus.req_size = 2'd2; bus.req_addr = 10'h010;
        @(posedge clk); #1;
        bus.req_valid = 0;
        chk("midread_in_read", 32'(bus.memory_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midread_flags", {27'd0, bus.busy, bus.done, bus.err, bus.memory_read, bus.memory_write}, 32'd0);
        chk("midread_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("midread_load_data", bus.load_data, 32'd0);
        exp_ld = 0;
        @(negedge clk) rst_n = 1'b1;
        no_done_for(3, "midread_no_done");
        model_req(0, 2'd2, 0, 10'h010, 0, lat, e, ld);
        exp_ld = ld;
        run_req(0, 2'd2, 0, 10'h010, 0, lat, e, ld, "after_reset_lw");

        // Reset in WRITE before the negedge: write must not land
        word = wmem[8];
        @(negedge clk);
        bus.req_valid = 1; bus.req_store = 1; bus.req_size = 2'd2; bus.req_addr = 10'h020;
        bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req_valid = 0;
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("wr_abort_before_negedge", wmem[8], word);
        exp_ld = 0;
        rst_n = 1'b1;
        no_done_for(3, "wr_abort_no_done");

        // Reset in WRITE after the negedge: write stays committed
        @(negedge clk);
        bus.req_valid = 1; bus.req_store = 1; bus.req_size = 2'd2; bus.req_addr = 10'h024;
        bus.req_wdata = 32'h12345678;
        @(posedge clk); #1;
        bus.req_valid = 0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("wr_after_negedge_kept", wmem[9], 32'h12345678);
        model_req(1, 2'd2, 0, 10'h024, 32'h12345678, lat, e, ld);
        exp_ld = 0;
        @(negedge clk) rst_n = 1'b1;
        no_done_for(3, "wr_kept_no_done");

        // req_valid held high: accept only in IDLE, one done per request
        @(negedge clk);
        bus.req_valid = 1; bus.req_store = 0; bus.req_size = 2'd2; bus.req_addr = 10'h024;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            chk($sformatf("held_done_c%0d", i), 32'(bus.done), (i % 3 == 2) ? 32'd1 : 32'd0);
            chk($sformatf("held_busy_c%0d", i), 32'(bus.busy), (i % 3 != 0) ? 32'd1 : 32'd0);
        end
        bus.req_valid = 0;
        exp_ld = 32'h12345678;
        chk("held_load_data", bus.load_data, exp_ld);

        // Random traffic against the model
        for (int n = 0; n < 200; n++) begin
            int r;
            logic st, un;
            logic [9:0] a;
            logic [31:0] wd;
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            st = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            wd = $urandom;
            model_req(st, sz, un, a, wd, lat, e, ld);
            exp_ld = ld;
            run_req(st, sz, un, a, wd, lat, e, ld, $sformatf("rnd%0d", n));
        end

        bad_words = 0;
        for (int w = 0; w < 256; w++) begin
            word = {rm[4 * w], rm[4 * w + 1], rm[4 * w + 2], rm[4 * w + 3]};
            if (wmem[w] !== word) bad_words++;
        end
        chk("final_memory_image", 32'(bad_words), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
